// File: rtl/debounce_ch.sv
// debounce_ch: one active-low push-button synchronized, debounced and edge-detected.
module debounce_ch #(
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bttn,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up
);
  logic [1:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             state_q, state_d;
  logic             idle, sat;
  always_comb begin
    sync_d  = {sync_q[0], ~bttn};
    idle    = sync_q[1] == state_q;
    sat     = ~idle & (&cnt_q);
    // the all-ones increment wraps to zero on the same edge the state toggles
    cnt_d   = idle ? '0 : cnt_q + CNT_W'(1);
    state_d = sat ? ~state_q : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end
  assign pb_state = state_q;
  assign pb_down  = sat & ~state_q;
  assign pb_up    = sat & state_q;
endmodule

// File: rtl/debounced_clksel.sv
// debounced_clksel: two debounced buttons; button 1 switches OUTCLK between FREE_CLK and button 0.
module debounced_clksel #(
  parameter int CNT_W = 16
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] BTTN,
  input  logic       FREE_CLK,
  output logic [1:0] PB_STATE,
  output logic [1:0] PB_DOWN,
  output logic [1:0] PB_UP,
  output logic       OUTCLK
);
  debounce_ch #(.CNT_W(CNT_W)) u_ch0 (
    .clk(CLK), .rst_n(RST_N), .bttn(BTTN[0]),
    .pb_state(PB_STATE[0]), .pb_down(PB_DOWN[0]), .pb_up(PB_UP[0])
  );
  debounce_ch #(.CNT_W(CNT_W)) u_ch1 (
    .clk(CLK), .rst_n(RST_N), .bttn(BTTN[1]),
    .pb_state(PB_STATE[1]), .pb_down(PB_DOWN[1]), .pb_up(PB_UP[1])
  );
  // plain mux, deliberately not retimed; a truncated pulse on switch is acceptable
  assign OUTCLK = PB_STATE[1] ? PB_STATE[0] : FREE_CLK;
endmodule

// File: tb/tb_debounced_clksel.sv
// tb_debounced_clksel: directed checks of debounce latency, bounce rejection, reset and clock select.
module tb_debounced_clksel;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] bttn = 2'b00;
  logic       free_clk = 1'b0;
  logic [1:0] pb_state, pb_down, pb_up;
  logic       outclk;
  int         n_vec = 0;
  int         n_err = 0;

  debounced_clksel #(.CNT_W(4)) u_dut (
    .CLK(clk), .RST_N(rst_n), .BTTN(bttn), .FREE_CLK(free_clk),
    .PB_STATE(pb_state), .PB_DOWN(pb_down), .PB_UP(pb_up), .OUTCLK(outclk)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    tick(3);
    chk("rst_state", {2'b0, pb_state}, 4'b0000);
    chk("rst_down", {2'b0, pb_down}, 4'b0000);
    chk("rst_up", {2'b0, pb_up}, 4'b0000);
    chk("rst_outclk0", {3'b0, outclk}, 4'b0000);
    free_clk = 1'b1;
    #1;
    chk("rst_outclk1", {3'b0, outclk}, 4'b0001);
    bttn = 2'b11;
    rst_n = 1'b1;
    tick(5);
    chk("idle_state", {2'b0, pb_state}, 4'b0000);
    // clean press of button 0: pulse between edges 17 and 18
    bttn = 2'b10;
    tick(16);
    chk("press_e16_down", {2'b0, pb_down}, 4'b0000);
    tick(1);
    chk("press_e17_down", {2'b0, pb_down}, 4'b0001);
    chk("press_e17_state", {2'b0, pb_state}, 4'b0000);
    chk("press_e17_up", {2'b0, pb_up}, 4'b0000);
    tick(1);
    chk("press_e18_down", {2'b0, pb_down}, 4'b0000);
    chk("press_e18_state", {2'b0, pb_state}, 4'b0001);
    tick(5);
    chk("press_hold_state", {2'b0, pb_state}, 4'b0001);
    chk("press_hold_down", {2'b0, pb_down}, 4'b0000);
    // release
    bttn = 2'b11;
    tick(16);
    chk("rel_e16_up", {2'b0, pb_up}, 4'b0000);
    tick(1);
    chk("rel_e17_up", {2'b0, pb_up}, 4'b0001);
    chk("rel_e17_state", {2'b0, pb_state}, 4'b0001);
    tick(1);
    chk("rel_e18_up", {2'b0, pb_up}, 4'b0000);
    chk("rel_e18_state", {2'b0, pb_state}, 4'b0000);
    // bounce: 10 cycles low then back high
    bttn = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("bounce_lo_down", {2'b0, pb_down}, 4'b0000);
    end
    bttn = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("bounce_hi_down", {2'b0, pb_down}, 4'b0000);
    end
    chk("bounce_state", {2'b0, pb_state}, 4'b0000);
    // simultaneous press and release of both buttons
    bttn = 2'b00;
    tick(17);
    chk("both_down", {2'b0, pb_down}, 4'b0011);
    tick(1);
    chk("both_state", {2'b0, pb_state}, 4'b0011);
    bttn = 2'b11;
    tick(17);
    chk("both_up", {2'b0, pb_up}, 4'b0011);
    tick(1);
    chk("both_rel_state", {2'b0, pb_state}, 4'b0000);
    // clock select
    bttn = 2'b01;
    tick(18);
    chk("sel_state", {2'b0, pb_state}, 4'b0010);
    free_clk = 1'b1;
    #1;
    chk("sel_outclk_lo", {3'b0, outclk}, 4'b0000);
    bttn = 2'b00;
    tick(17);
    chk("sel_step_down", {2'b0, pb_down}, 4'b0001);
    tick(1);
    chk("sel_outclk_hi", {3'b0, outclk}, 4'b0001);
    free_clk = 1'b0;
    #1;
    chk("sel_outclk_hold", {3'b0, outclk}, 4'b0001);
    bttn = 2'b01;
    tick(18);
    chk("sel_outclk_fall", {3'b0, outclk}, 4'b0000);
    bttn = 2'b11;
    tick(18);
    chk("desel_state", {2'b0, pb_state}, 4'b0000);
    free_clk = 1'b1;
    #1;
    chk("desel_outclk", {3'b0, outclk}, 4'b0001);
    // async reset at count 8, then full requalification
    bttn = 2'b10;
    tick(10);
    chk("mid_cnt8", u_dut.u_ch0.cnt_q, 4'd8);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt", u_dut.u_ch0.cnt_q, 4'd0);
    chk("mid_rst_state", {2'b0, pb_state}, 4'b0000);
    tick(3);
    rst_n = 1'b1;
    tick(16);
    chk("rq_e16_down", {2'b0, pb_down}, 4'b0000);
    chk("rq_e16_state", {2'b0, pb_state}, 4'b0000);
    tick(1);
    chk("rq_e17_down", {2'b0, pb_down}, 4'b0001);
    tick(1);
    chk("rq_e18_state", {2'b0, pb_state}, 4'b0001);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/debounced_clksel.md
DEBOUNCED_CLKSEL -- requirements
Module: debounced_clksel

Interface
REQ-001 Parameter CNT_W, default 16: width of each debounce counter; stable time is 2^CNT_W-1 CLK cycles.
REQ-002 CLK  input  1  sampling clock for all registers; rising edge active.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 BTTN  input  2  raw push-buttons, active-low (0 = pressed); BTTN[0] = manual step clock, BTTN[1] = alternate-select.
REQ-005 FREE_CLK  input  1  free-running slow clock; treated as a data signal, never as a register clock.
REQ-006 PB_STATE  output  2  debounced button state, active-high (1 = pressed).
REQ-007 PB_DOWN  output  2  one-CLK-cycle pulse per debounced press.
REQ-008 PB_UP  output  2  one-CLK-cycle pulse per debounced release.
REQ-009 OUTCLK  output  1  selected clock: FREE_CLK when PB_STATE[1]=0, PB_STATE[0] when PB_STATE[1]=1.

Function
REQ-010 Each button SHALL pass through a 2-flop synchronizer storing the inverted input, so sync=1 means pressed.
REQ-011 Idle SHALL be defined as sync stage 2 equal to PB_STATE; when idle, the counter SHALL clear to 0.
REQ-012 When not idle, the counter SHALL increment by 1 per CLK cycle.
REQ-013 When the counter is all ones and not idle, PB_STATE SHALL toggle on the next edge.
REQ-014 When PB_STATE toggles, the counter SHALL wrap to 0.
REQ-015 PB_DOWN SHALL be combinational: (not idle) AND (counter all ones) AND (PB_STATE=0).
REQ-016 PB_UP SHALL be combinational: (not idle) AND (counter all ones) AND (PB_STATE=1).
REQ-017 Latency: the edge that first samples a new stable level counts as edge 1; PB_DOWN/PB_UP SHALL be high between edges 2^CNT_W+1 and 2^CNT_W+2; PB_STATE SHALL change at edge 2^CNT_W+2.
REQ-018 Bounce: any return to the idle level before the counter saturates SHALL clear the counter with no change to PB_STATE and no pulse.
REQ-019 The two button channels SHALL be fully independent; simultaneous presses each produce their own pulse in the same cycle.
REQ-020 OUTCLK SHALL be a purely combinational 2:1 mux selected by PB_STATE[1]; it SHALL NOT be retimed.
REQ-021 Switching the select MAY produce one truncated OUTCLK pulse; no glitch suppression SHALL be added.
REQ-022 The counter SHALL be exactly CNT_W bits, unsigned, with no saturation logic beyond REQ-013/REQ-014.

Reset
REQ-023 While RST_N=0, synchronizer flops SHALL hold 0 (released), counters 0, and PB_STATE 0.
REQ-024 During reset, PB_DOWN and PB_UP SHALL be 0, and OUTCLK SHALL equal FREE_CLK.
REQ-025 Reset deassertion mid-debounce SHALL restart the qualification from count 0.

Structure
REQ-026 No shared package is needed; CNT_W is the only constant and stays local.
REQ-027 One sub-module, debounce_ch, SHALL implement a single channel (synchronizer, counter, state, pulses); the top SHALL instantiate it twice and add the mux.

Verification
REQ-028 Run all scenarios with CNT_W=4.
REQ-029 Reset: RST_N=0 with BTTN=2'b00 -> PB_STATE=00, PB_DOWN=PB_UP=00, OUTCLK follows FREE_CLK.
REQ-030 Clean press: BTTN[0] 1->0 held -> PB_DOWN[0] high for exactly one cycle between edges 17 and 18, PB_STATE[0]=1 from edge 18.
REQ-031 Bounce: BTTN[0] low for 10 cycles, then high -> no PB_DOWN pulse, PB_STATE[0] stays 0.
REQ-032 Release: after a press, BTTN[0] 0->1 held -> PB_UP[0] single pulse, PB_STATE[0]=0 at edge 18.
REQ-033 Select: press BTTN[1] -> after debounce, OUTCLK follows PB_STATE[0]; toggling BTTN[0] produces matching OUTCLK edges; releasing BTTN[1] returns OUTCLK to FREE_CLK.
REQ-034 Async reset mid-count: assert RST_N=0 at count 8 -> counter 0 immediately; after release, a full 2^CNT_W qualification is required before PB_STATE changes.
